// File: rtl/conway_pkg.sv
// Shared types and defaults for the conway board datapath.
package conway_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } reader_state_t;

  localparam int unsigned BOARD_ROWS = 12;
  localparam int unsigned BOARD_COLS = 12;

  // Index width for a dimension of n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grid_scan_counter.sv
// Row-major (row, col) scan counter over a ROWS x COLS grid.
// clear takes priority over step; stepping past the last cell wraps to (0,0).
module grid_scan_counter
  import conway_pkg::*;
#(
  parameter int unsigned ROWS = BOARD_ROWS,
  parameter int unsigned COLS = BOARD_COLS,
  localparam int unsigned RW = idx_width(ROWS),
  localparam int unsigned CW = idx_width(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          at_last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic row_end;
  logic col_end;

  assign row_end = (row == ROW_MAX);
  assign col_end = (col == COL_MAX);
  assign at_last = row_end && col_end;

  // Advance column first, carrying into the row; both wrap at their maxima
  // so non-power-of-two dimensions never leave the grid.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (col_end) begin
        col <= '0;
        if (row_end) begin
          row <= '0;
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conway_frame_reader.sv
// Snapshots the board's cell states and streams them one pixel per
// valid/ready transfer, row-major, with coordinates and a last marker.
module conway_frame_reader
  import conway_pkg::*;
#(
  parameter int unsigned ROWS = BOARD_ROWS,
  parameter int unsigned COLS = BOARD_COLS,
  localparam int unsigned RW = idx_width(ROWS),
  localparam int unsigned CW = idx_width(COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] cells,
  input  logic                 snap,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_pixel,
  output logic [RW-1:0]        out_row,
  output logic [CW-1:0]        out_col,
  output logic                 out_last,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned IW = $clog2(N) + 1;

  reader_state_t state;
  reader_state_t state_next;

  logic [N-1:0]  shadow;
  logic          capture;
  logic          step;
  logic          clear;
  logic          at_last;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [IW-1:0] bit_idx;
  logic [N-1:0]  bit_sel;

  grid_scan_counter #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .step   (step),
    .row    (row),
    .col    (col),
    .at_last(at_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake/status outputs.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    step       = 1'b0;
    clear      = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (snap) begin
          capture    = 1'b1;
          clear      = 1'b1;
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          step = 1'b1;
          if (at_last) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        clear      = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Shadow copy of the board, taken only when a frame is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= '0;
    end else if (capture) begin
      shadow <= cells;
    end
  end

  // Sticky flag: a snap arrived while a frame was still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (snap && (state != S_IDLE)) begin
      overrun <= 1'b1;
    end
  end

  // Bit index widened so row*COLS+col cannot truncate; a one-hot mask
  // selects the pixel without an out-of-range index on odd dimensions.
  assign bit_idx   = IW'(row) * IW'(COLS) + IW'(col);
  assign bit_sel   = N'(1) << bit_idx;
  assign out_pixel = out_valid & (|(shadow & bit_sel));
  assign out_last  = out_valid & at_last;
  assign out_row   = row;
  assign out_col   = col;

endmodule

// File: tb/tb_conway_frame_reader.sv
// Bench for conway_frame_reader: three instances (3x3, 5x3, 1x1) checked
// every cycle against a frame-level reference model.
module tb_conway_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic snap  [3];
  logic ready [3];
  logic busy  [3];
  logic valid [3];
  logic pixel [3];
  logic last  [3];
  logic fdone [3];
  logic ovr   [3];

  logic [8:0]  cells0;
  logic [14:0] cells1;
  logic [0:0]  cells2;
  logic [1:0]  row0;
  logic [2:0]  row1;
  logic [0:0]  row2;
  logic [1:0]  col0;
  logic [1:0]  col1;
  logic [0:0]  col2;

  conway_frame_reader #(.ROWS(3), .COLS(3)) u_dut_3x3 (
    .clk(clk), .rst(rst), .cells(cells0), .snap(snap[0]), .busy(busy[0]),
    .out_valid(valid[0]), .out_ready(ready[0]), .out_pixel(pixel[0]),
    .out_row(row0), .out_col(col0), .out_last(last[0]),
    .frame_done(fdone[0]), .overrun(ovr[0])
  );

  conway_frame_reader #(.ROWS(5), .COLS(3)) u_dut_5x3 (
    .clk(clk), .rst(rst), .cells(cells1), .snap(snap[1]), .busy(busy[1]),
    .out_valid(valid[1]), .out_ready(ready[1]), .out_pixel(pixel[1]),
    .out_row(row1), .out_col(col1), .out_last(last[1]),
    .frame_done(fdone[1]), .overrun(ovr[1])
  );

  conway_frame_reader #(.ROWS(1), .COLS(1)) u_dut_1x1 (
    .clk(clk), .rst(rst), .cells(cells2), .snap(snap[2]), .busy(busy[2]),
    .out_valid(valid[2]), .out_ready(ready[2]), .out_pixel(pixel[2]),
    .out_row(row2), .out_col(col2), .out_last(last[2]),
    .frame_done(fdone[2]), .overrun(ovr[2])
  );

  int dim_r [3] = '{3, 5, 1};
  int dim_c [3] = '{3, 3, 1};

  // Reference model: a frame is the captured bit vector plus the index of
  // the next pixel to hand out (-1 when no frame is in flight).
  int          m_k      [3] = '{-1, -1, -1};
  bit          m_done   [3] = '{0, 0, 0};
  bit          m_ovr    [3] = '{0, 0, 0};
  logic [14:0] m_shadow [3] = '{15'd0, 15'd0, 15'd0};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [14:0] cells_of(input int i);
    case (i)
      0:       return 15'(cells0);
      1:       return cells1;
      default: return 15'(cells2);
    endcase
  endfunction

  function automatic logic [31:0] row_of(input int i);
    case (i)
      0:       return 32'(row0);
      1:       return 32'(row1);
      default: return 32'(row2);
    endcase
  endfunction

  function automatic logic [31:0] col_of(input int i);
    case (i)
      0:       return 32'(col0);
      1:       return 32'(col1);
      default: return 32'(col2);
    endcase
  endfunction

  always @(posedge clk) begin : model
    int  n;
    bit  was_busy;
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_k[i]      = -1;
        m_done[i]   = 1'b0;
        m_ovr[i]    = 1'b0;
        m_shadow[i] = '0;
      end else begin
        n        = dim_r[i] * dim_c[i];
        was_busy = (m_k[i] >= 0) || m_done[i];
        m_done[i] = 1'b0;
        if (m_k[i] >= 0 && ready[i]) begin
          m_k[i] = m_k[i] + 1;
          if (m_k[i] == n) begin
            m_k[i]    = -1;
            m_done[i] = 1'b1;
          end
        end
        if (snap[i]) begin
          if (was_busy) begin
            m_ovr[i] = 1'b1;
          end else begin
            m_shadow[i] = cells_of(i);
            m_k[i]      = 0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    int k;
    int n;
    bit v;
    logic [31:0] e_pix;
    for (int i = 0; i < 3; i++) begin
      k = m_k[i];
      n = dim_r[i] * dim_c[i];
      v = (k >= 0);
      e_pix = 0;
      if (v) e_pix = 32'(m_shadow[i][k]);
      check($sformatf("valid[%0d]", i), 32'(valid[i]), 32'(v));
      check($sformatf("busy[%0d]", i),  32'(busy[i]),  32'(v));
      check($sformatf("pixel[%0d]", i), 32'(pixel[i]), e_pix);
      check($sformatf("row[%0d]", i),   row_of(i),     v ? k / dim_c[i] : 0);
      check($sformatf("col[%0d]", i),   col_of(i),     v ? k % dim_c[i] : 0);
      check($sformatf("last[%0d]", i),  32'(last[i]),  32'(k == n - 1));
      check($sformatf("frame_done[%0d]", i), 32'(fdone[i]), 32'(m_done[i]));
      check($sformatf("overrun[%0d]", i),    32'(ovr[i]),   32'(m_ovr[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    rst    = 1'b0;
    cells0 = '0;
    cells1 = '0;
    cells2 = '0;
    for (int i = 0; i < 3; i++) begin
      snap[i]  = 1'b0;
      ready[i] = 1'b0;
    end
    repeat (3) cycle();
    rst = 1'b1;
    cycle();

    // Full-speed frame of a checkerboard.
    cells0 = 9'b101010101;
    ready[0] = 1'b1;
    snap[0]  = 1'b1;
    cycle();
    snap[0] = 1'b0;
    repeat (12) cycle();

    // Same frame with stalls: ready pattern 1,0,0,...
    snap[0] = 1'b1;
    cycle();
    snap[0] = 1'b0;
    for (int j = 0; j < 32; j++) begin
      ready[0] = (j % 3 == 0);
      cycle();
    end

    // Board changes after capture must not leak into the frame.
    ready[0] = 1'b1;
    snap[0]  = 1'b1;
    cycle();
    snap[0] = 1'b0;
    repeat (2) cycle();
    cells0 = '0;
    repeat (10) cycle();
    cells0 = 9'b101010101;

    // Overrun: snap mid-frame and during the done cycle, then a real re-snap.
    snap[0] = 1'b1;
    cycle();
    snap[0] = 1'b0;
    repeat (4) cycle();
    snap[0] = 1'b1;
    cycle();
    snap[0] = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (fdone[0]) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("frame_done_seen", 32'(found), 32'd1);
    snap[0] = 1'b1;
    cycle();
    cycle();
    snap[0] = 1'b0;
    repeat (12) cycle();

    // Reset in the middle of a frame, then a fresh frame.
    cells0 = 9'b110011010;
    snap[0] = 1'b1;
    cycle();
    snap[0] = 1'b0;
    repeat (5) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    repeat (2) cycle();
    snap[0] = 1'b1;
    cycle();
    snap[0] = 1'b0;
    repeat (12) cycle();

    // Full-speed frames on the odd-shaped and single-cell boards.
    cells1 = 15'($urandom);
    cells2 = 1'b1;
    ready[1] = 1'b1;
    ready[2] = 1'b1;
    snap[1]  = 1'b1;
    snap[2]  = 1'b1;
    cycle();
    snap[1] = 1'b0;
    snap[2] = 1'b0;
    repeat (18) cycle();

    // Random traffic on all boards.
    for (int t = 0; t < 800; t++) begin
      cells0 = 9'($urandom);
      cells1 = 15'($urandom);
      cells2 = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
        snap[i]  = ($urandom_range(0, 9) == 0);
        ready[i] = ($urandom_range(0, 3) != 0);
      end
      if (t == 400) rst = 1'b0;
      else          rst = 1'b1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
